lsb_queue: RTL and testbench

- Parametrised load/store buffer for the out-of-order RV32I core; replaces the fixed 10-entry shifting buffer.
- Circular queue that accepts load/store ops from dispatch and snoops CDB_NUM broadcast buses for operands.
- Issues memory requests strictly in program order; stores go to memory only after ROB commit.
- Broadcasts sign/zero-extended load results on its own CDB port; flushes speculative entries on clear.

---
 rtl/lsb_queue.sv | 272 +++++++++++++++++++++++++++
 tb/tb_lsb_queue.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsb_queue.sv
// Purpose: in-order load/store queue with CDB operand snooping, commit-gated stores and load-result broadcast.
// Latency: memory request the cycle after the head becomes eligible; load result one cycle after mem_done.
// Backpressure: issue_ready drops when all DEPTH entries are occupied; mem_req is held until mem_done.
module lsb_queue #(
  parameter int DEPTH   = 16,
  parameter int PTR_W   = 4,
  parameter int TAG_W   = 5,
  parameter int CDB_NUM = 3
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   rdy_in,
  input  logic                   clear,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [TAG_W-1:0]       issue_tag,
  input  logic                   issue_is_store,
  input  logic [2:0]             issue_funct3,
  input  logic [TAG_W-1:0]       issue_qj,
  input  logic [TAG_W-1:0]       issue_qk,
  input  logic [31:0]            issue_vj,
  input  logic [31:0]            issue_vk,
  input  logic [31:0]            issue_imm,
  input  logic [CDB_NUM-1:0]     cdb_valid,
  input  logic [CDB_NUM*TAG_W-1:0] cdb_tag,
  input  logic [CDB_NUM*32-1:0]  cdb_value,
  input  logic                   commit_valid,
  input  logic [TAG_W-1:0]       commit_tag,
  output logic                   mem_req,
  output logic                   mem_wr,
  output logic [31:0]            mem_addr,
  output logic [1:0]             mem_size,
  output logic [31:0]            mem_wdata,
  input  logic                   mem_done,
  input  logic [31:0]            mem_rdata,
  output logic                   out_valid,
  output logic [TAG_W-1:0]       out_tag,
  output logic [31:0]            out_value
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             is_store;
    logic [2:0]       funct3;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [31:0]      imm;
    logic             committed;
  } entry_t;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  state_t           state_q, state_d;

  entry_t           head_ent;
  logic             enq, start, pop, load_done, head_elig, inflight_load;
  logic [PTR_W:0]   commit_cnt, kept;
  logic [TAG_W-1:0] fwd_qj, fwd_qk;
  logic [31:0]      fwd_vj, fwd_vk;
  logic             out_valid_q;

  assign head_ent      = ent_q[head_q];
  assign issue_ready   = (cnt_q != DEPTH_CNT);
  assign enq           = issue_valid && issue_ready && !clear;
  assign out_valid     = out_valid_q && rdy_in;
  // The in-flight load keeps its slot through a flush until memory answers.
  assign inflight_load = (state_q != IDLE) && !head_ent.is_store;
  assign head_elig     = vld_q[head_q] &&
                         (head_ent.is_store ? (head_ent.qj == '0 && head_ent.qk == '0 && head_ent.committed)
                                            : (head_ent.qj == '0));

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b100:  return {24'h0, d[7:0]};
      3'b101:  return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  // Same-cycle CDB forwarding for the op being dispatched; lowest bus index wins.
  always_comb begin
    fwd_qj = issue_qj;
    fwd_vj = issue_vj;
    fwd_qk = issue_qk;
    fwd_vk = issue_vk;
    for (int k = CDB_NUM-1; k >= 0; k--) begin
      if (cdb_valid[k] && issue_qj != '0 && issue_qj == cdb_tag[k*TAG_W +: TAG_W]) begin
        fwd_qj = '0;
        fwd_vj = cdb_value[k*32 +: 32];
      end
      if (cdb_valid[k] && issue_qk != '0 && issue_qk == cdb_tag[k*TAG_W +: TAG_W]) begin
        fwd_qk = '0;
        fwd_vk = cdb_value[k*32 +: 32];
      end
    end
  end

  // Length of the committed-store run starting at head; this is what survives a flush.
  always_comb begin
    logic             in_prefix;
    logic [PTR_W-1:0] idx;
    commit_cnt = '0;
    in_prefix  = 1'b1;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (in_prefix && vld_q[idx] && ent_q[idx].committed)
        commit_cnt = commit_cnt + (PTR_W+1)'(1);
      else
        in_prefix = 1'b0;
    end
    kept = inflight_load ? (PTR_W+1)'(1) : commit_cnt;
  end

  // Memory FSM next state: start on an eligible head, finish on mem_done, drain a flushed load.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    pop       = 1'b0;
    load_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (head_elig && !clear) begin
          start   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_done) begin
          pop       = 1'b1;
          load_done = !head_ent.is_store && !clear;
          state_d   = IDLE;
        end else if (clear && !head_ent.is_store) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_done) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry array next state: snoop, commit, enqueue, flush and pop.
  always_comb begin
    logic [PTR_W-1:0] off;
    off = '0;
    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
    vld_d = vld_q;
    if (!clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i]) begin
          for (int k = CDB_NUM-1; k >= 0; k--) begin
            if (cdb_valid[k] && ent_q[i].qj != '0 && ent_q[i].qj == cdb_tag[k*TAG_W +: TAG_W]) begin
              ent_d[i].qj = '0;
              ent_d[i].vj = cdb_value[k*32 +: 32];
            end
            if (cdb_valid[k] && ent_q[i].qk != '0 && ent_q[i].qk == cdb_tag[k*TAG_W +: TAG_W]) begin
              ent_d[i].qk = '0;
              ent_d[i].vk = cdb_value[k*32 +: 32];
            end
          end
          if (commit_valid && ent_q[i].is_store && ent_q[i].tag == commit_tag)
            ent_d[i].committed = 1'b1;
        end
      end
    end
    if (enq) begin
      ent_d[tail_q] = '{tag: issue_tag, is_store: issue_is_store, funct3: issue_funct3,
                        qj: fwd_qj, qk: fwd_qk, vj: fwd_vj, vk: fwd_vk,
                        imm: issue_imm, committed: 1'b0};
      vld_d[tail_q] = 1'b1;
    end
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        off = PTR_W'(i) - head_q;
        if ({1'b0, off} >= kept) begin
          vld_d[i]           = 1'b0;
          ent_d[i].committed = 1'b0;
        end
      end
    end
    if (pop) begin
      vld_d[head_q]           = 1'b0;
      ent_d[head_q].committed = 1'b0;
    end
  end

  // Pointer and occupancy next state; a flush truncates the queue to the surviving prefix.
  always_comb begin
    head_d = head_q + PTR_W'(pop);
    if (clear) begin
      tail_d = head_q + kept[PTR_W-1:0];
      cnt_d  = kept - (PTR_W+1)'(pop);
    end else begin
      tail_d = tail_q + PTR_W'(enq);
      cnt_d  = cnt_q + (PTR_W+1)'(enq) - (PTR_W+1)'(pop);
    end
  end

  // Queue state registers; frozen while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
    end else if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Memory request registers: loaded on start, held stable, request dropped on completion.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_size  <= '0;
      mem_wdata <= '0;
    end else if (rdy_in) begin
      if (start) begin
        mem_req   <= 1'b1;
        mem_wr    <= head_ent.is_store;
        mem_addr  <= head_ent.vj + head_ent.imm;
        mem_size  <= head_ent.funct3[1:0];
        mem_wdata <= head_ent.vk;
      end else if (pop) begin
        mem_req <= 1'b0;
      end
    end
  end

  // Load result broadcast: one-cycle pulse carrying the extended read data.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      out_valid_q <= 1'b0;
      out_tag     <= '0;
      out_value   <= '0;
    end else if (!rdy_in) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= load_done;
      if (load_done) begin
        out_tag   <= head_ent.tag;
        out_value <= extend(head_ent.funct3, mem_rdata);
      end
    end
  end

endmodule

// File: tb/tb_lsb_queue.sv
// Purpose: directed self-checking bench for lsb_queue (load table plus multi-cycle corner sequences).
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: every wait on the DUT is cycle-bounded.
module tb_lsb_queue;

  logic        clk_in, rst_n_in, rdy_in, clear;
  logic        issue_valid, issue_ready, issue_is_store;
  logic [4:0]  issue_tag, issue_qj, issue_qk;
  logic [2:0]  issue_funct3;
  logic [31:0] issue_vj, issue_vk, issue_imm;
  logic [2:0]  cdb_valid;
  logic [14:0] cdb_tag;
  logic [95:0] cdb_value;
  logic        commit_valid;
  logic [4:0]  commit_tag;
  logic        mem_req, mem_wr, mem_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;
  logic        out_valid;
  logic [4:0]  out_tag;
  logic [31:0] out_value;

  int n_pass = 0;
  int n_tot  = 0;

  lsb_queue #(.DEPTH(16), .PTR_W(4), .TAG_W(5), .CDB_NUM(3)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear(clear),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
    .issue_is_store(issue_is_store), .issue_funct3(issue_funct3),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_imm(issue_imm), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_tag(out_tag), .out_value(out_value)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [4:0]  tag;
    logic [2:0]  f3;
    logic [31:0] vj;
    logic [31:0] imm;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [1:0]  exp_size;
    logic [31:0] exp_val;
  } ld_vec_t;

  ld_vec_t vecs [6];

  task automatic cyc();
    @(negedge clk_in);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic enq(input logic [4:0] tag, input logic st, input logic [2:0] f3,
                     input logic [4:0] qj, input logic [4:0] qk,
                     input logic [31:0] vj, input logic [31:0] vk, input logic [31:0] imm);
    issue_valid = 1'b1; issue_tag = tag; issue_is_store = st; issue_funct3 = f3;
    issue_qj = qj; issue_qk = qk; issue_vj = vj; issue_vk = vk; issue_imm = imm;
    cyc();
    issue_valid = 1'b0; issue_qj = '0; issue_qk = '0;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!mem_req && n < 100) begin
      cyc();
      n++;
    end
    chk(name, 32'(mem_req), 32'd1);
  endtask

  task automatic done_pulse(input logic [31:0] rdata);
    mem_done = 1'b1; mem_rdata = rdata;
    cyc();
    mem_done = 1'b0;
  endtask

  initial begin
    vecs[0] = '{5'd3,  3'b000, 32'h0000_0100, 32'h0000_0004, 32'h0000_00F0, 32'h0000_0104, 2'd0, 32'hFFFF_FFF0};
    vecs[1] = '{5'd4,  3'b100, 32'h0000_0100, 32'h0000_0004, 32'h0000_00F0, 32'h0000_0104, 2'd0, 32'h0000_00F0};
    vecs[2] = '{5'd6,  3'b001, 32'h0000_2000, 32'hFFFF_FFFE, 32'h1234_8001, 32'h0000_1FFE, 2'd1, 32'hFFFF_8001};
    vecs[3] = '{5'd8,  3'b101, 32'h0000_0010, 32'h0000_0020, 32'hABCD_8001, 32'h0000_0030, 2'd1, 32'h0000_8001};
    vecs[4] = '{5'd10, 3'b010, 32'hFFFF_FFFC, 32'h0000_0008, 32'hCAFE_BABE, 32'h0000_0004, 2'd2, 32'hCAFE_BABE};
    vecs[5] = '{5'd11, 3'b000, 32'h0000_0000, 32'h0000_0000, 32'h0000_007F, 32'h0000_0000, 2'd0, 32'h0000_007F};

    rst_n_in = 1'b0; rdy_in = 1'b1; clear = 1'b0;
    issue_valid = 1'b0; issue_tag = '0; issue_is_store = 1'b0; issue_funct3 = '0;
    issue_qj = '0; issue_qk = '0; issue_vj = '0; issue_vk = '0; issue_imm = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
    commit_valid = 1'b0; commit_tag = '0; mem_done = 1'b0; mem_rdata = '0;

    // Reset values
    #1;
    chk("rst_mem_req",   32'(mem_req),   32'd0);
    chk("rst_mem_wr",    32'(mem_wr),    32'd0);
    chk("rst_mem_addr",  mem_addr,       32'd0);
    chk("rst_mem_size",  32'(mem_size),  32'd0);
    chk("rst_mem_wdata", mem_wdata,      32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_tag",   32'(out_tag),   32'd0);
    chk("rst_out_value", out_value,      32'd0);
    chk("rst_ready",     32'(issue_ready), 32'd1);
    cyc(); cyc();
    rst_n_in = 1'b1;
    cyc();

    // Load table: address, size, extension
    for (int v = 0; v < 6; v++) begin
      enq(vecs[v].tag, 1'b0, vecs[v].f3, 5'd0, 5'd0, vecs[v].vj, 32'h0, vecs[v].imm);
      chk($sformatf("ld%0d_idle", v), 32'(mem_req), 32'd0);
      cyc();
      chk($sformatf("ld%0d_req", v),  32'(mem_req), 32'd1);
      chk($sformatf("ld%0d_wr", v),   32'(mem_wr), 32'd0);
      chk($sformatf("ld%0d_addr", v), mem_addr, vecs[v].exp_addr);
      chk($sformatf("ld%0d_size", v), 32'(mem_size), 32'(vecs[v].exp_size));
      done_pulse(vecs[v].rdata);
      chk($sformatf("ld%0d_ov", v),   32'(out_valid), 32'd1);
      chk($sformatf("ld%0d_tag", v),  32'(out_tag), 32'(vecs[v].tag));
      chk($sformatf("ld%0d_val", v),  out_value, vecs[v].exp_val);
      chk($sformatf("ld%0d_req0", v), 32'(mem_req), 32'd0);
      cyc();
      chk($sformatf("ld%0d_pulse", v), 32'(out_valid), 32'd0);
    end

    // Store waits for operand and commit
    enq(5'd5, 1'b1, 3'b010, 5'd0, 5'd7, 32'h200, 32'h0, 32'h10);
    cyc(); cyc();
    chk("st_wait_dep", 32'(mem_req), 32'd0);
    cdb_valid = 3'b100; cdb_tag = {5'd7, 5'd0, 5'd0}; cdb_value = {32'hDEADBEEF, 64'h0};
    cyc();
    cdb_valid = '0;
    cyc(); cyc();
    chk("st_wait_commit", 32'(mem_req), 32'd0);
    commit_valid = 1'b1; commit_tag = 5'd5;
    cyc();
    commit_valid = 1'b0;
    cyc();
    chk("st_req",   32'(mem_req), 32'd1);
    chk("st_wr",    32'(mem_wr),  32'd1);
    chk("st_wdata", mem_wdata,    32'hDEADBEEF);
    chk("st_addr",  mem_addr,     32'h210);
    done_pulse(32'h0);
    chk("st_no_bcast", 32'(out_valid), 32'd0);
    chk("st_req0",     32'(mem_req),   32'd0);

    // Issue-cycle forwarding, duplicate tag on two buses: bus 1 beats bus 2
    cdb_valid = 3'b110; cdb_tag = {5'd9, 5'd9, 5'd0}; cdb_value = {32'h80, 32'h40, 32'h0};
    enq(5'd12, 1'b0, 3'b010, 5'd9, 5'd0, 32'h999, 32'h0, 32'h8);
    cdb_valid = '0;
    cyc();
    chk("fwd_req",  32'(mem_req), 32'd1);
    chk("fwd_addr", mem_addr,     32'h48);
    done_pulse(32'h1234_5678);
    chk("fwd_tag", 32'(out_tag), 32'd12);

    // Fill to DEPTH across the pointer wrap, refuse issue on a full-queue pop, keep order
    for (int t = 1; t <= 16; t++) enq(5'(t), 1'b0, 3'b010, 5'd0, 5'd0, 32'(t * 16), 32'h0, 32'h0);
    chk("full_ready", 32'(issue_ready), 32'd0);
    chk("full_addr1", mem_addr, 32'd16);
    issue_valid = 1'b1; issue_tag = 5'd17; issue_is_store = 1'b0; issue_funct3 = 3'b010;
    issue_vj = 32'(17 * 16); issue_imm = 32'h0;
    mem_done = 1'b1; mem_rdata = 32'h111;
    cyc();
    issue_valid = 1'b0; mem_done = 1'b0;
    chk("full_pop_tag", 32'(out_tag), 32'd1);
    chk("full_pop_ready", 32'(issue_ready), 32'd1);
    begin
      int nxt;
      nxt = 17;
      for (int e = 2; e <= 20; e++) begin
        wait_req($sformatf("ord%0d_req", e));
        chk($sformatf("ord%0d_addr", e), mem_addr, 32'(e * 16));
        mem_done = 1'b1; mem_rdata = 32'(e * 32'h111);
        if (nxt <= 20) begin
          issue_valid = 1'b1; issue_tag = 5'(nxt); issue_vj = 32'(nxt * 16);
          nxt++;
        end
        cyc();
        mem_done = 1'b0; issue_valid = 1'b0;
        chk($sformatf("ord%0d_tag", e), 32'(out_tag), 32'(e));
        chk($sformatf("ord%0d_val", e), out_value, 32'(e * 32'h111));
      end
    end

    // Flush: committed store A in flight survives, B and C dropped
    enq(5'd21, 1'b1, 3'b010, 5'd0, 5'd0, 32'h300, 32'hA5A5A5A5, 32'h0);
    enq(5'd22, 1'b0, 3'b010, 5'd0, 5'd0, 32'h400, 32'h0, 32'h0);
    enq(5'd23, 1'b1, 3'b010, 5'd0, 5'd0, 32'h500, 32'h1, 32'h0);
    commit_valid = 1'b1; commit_tag = 5'd21;
    cyc();
    commit_valid = 1'b0;
    cyc();
    chk("clrA_req",   32'(mem_req), 32'd1);
    chk("clrA_wdata", mem_wdata,    32'hA5A5A5A5);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clrA_hold", 32'(mem_req), 32'd1);
    chk("clrA_wr",   32'(mem_wr),  32'd1);
    done_pulse(32'h0);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        if (mem_req || out_valid) seen = 1'b1;
        cyc();
      end
      chk("clrB_dropped", 32'(seen), 32'd0);
    end
    // Empty after the flush: exactly 16 more entries fit
    for (int t = 1; t <= 15; t++) enq(5'(t), 1'b0, 3'b010, 5'd30, 5'd0, 32'h0, 32'h0, 32'h0);
    chk("clr_cnt15_ready", 32'(issue_ready), 32'd1);
    enq(5'd16, 1'b0, 3'b010, 5'd30, 5'd0, 32'h0, 32'h0, 32'h0);
    chk("clr_cnt16_ready", 32'(issue_ready), 32'd0);
    chk("dep_no_req",      32'(mem_req),     32'd0);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clr_all_ready", 32'(issue_ready), 32'd1);

    // Flush while head load is in flight: result discarded, queue keeps working
    enq(5'd24, 1'b0, 3'b010, 5'd0, 5'd0, 32'h600, 32'h0, 32'h0);
    cyc();
    chk("drain_req", 32'(mem_req), 32'd1);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    cyc();
    chk("drain_hold", 32'(mem_req), 32'd1);
    done_pulse(32'h5555_5555);
    chk("drain_silent", 32'(out_valid), 32'd0);
    chk("drain_req0",   32'(mem_req),   32'd0);
    enq(5'd25, 1'b0, 3'b010, 5'd0, 5'd0, 32'h700, 32'h0, 32'h4);
    cyc();
    chk("post_drain_addr", mem_addr, 32'h704);
    done_pulse(32'h77);
    chk("post_drain_tag", 32'(out_tag), 32'd25);

    // rdy_in low: issue ignored, mem_done ignored, state frozen
    rdy_in = 1'b0;
    enq(5'd26, 1'b0, 3'b010, 5'd0, 5'd0, 32'h800, 32'h0, 32'h0);
    cyc();
    rdy_in = 1'b1;
    cyc(); cyc();
    chk("rdy_issue_ignored", 32'(mem_req), 32'd0);
    enq(5'd26, 1'b0, 3'b010, 5'd0, 5'd0, 32'h800, 32'h0, 32'h0);
    cyc();
    chk("rdy_req", 32'(mem_req), 32'd1);
    rdy_in = 1'b0;
    done_pulse(32'h99);
    chk("rdy_done_ignored", 32'(mem_req),   32'd1);
    chk("rdy_no_out",       32'(out_valid), 32'd0);
    rdy_in = 1'b1;
    cyc();
    chk("rdy_still_busy", 32'(mem_req), 32'd1);
    done_pulse(32'h99);
    chk("rdy_out_tag", 32'(out_tag), 32'd26);

    // Reset in the middle of a transaction
    enq(5'd27, 1'b0, 3'b010, 5'd0, 5'd0, 32'h900, 32'h0, 32'h0);
    cyc();
    chk("mid_req", 32'(mem_req), 32'd1);
    rst_n_in = 1'b0;
    #1;
    chk("mid_rst_req",   32'(mem_req),     32'd0);
    chk("mid_rst_addr",  mem_addr,         32'd0);
    chk("mid_rst_ready", 32'(issue_ready), 32'd1);
    cyc();
    rst_n_in = 1'b1;
    cyc(); cyc(); cyc();
    chk("mid_rst_empty", 32'(mem_req), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
